// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for ARMv4 MUL/MLA/UMULL/SMULL with tri-state result bus
module mul_unit #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MUL_START,
  input  logic        MUL_ACC,
  input  logic        MUL_LONG,
  input  logic        MUL_SIGNED,
  input  logic [31:0] A_BUS,
  input  logic [31:0] B_BUS,
  input  logic [31:0] C_BUS,
  input  logic        MUL_GATE_LO,
  input  logic        MUL_GATE_HI,
  output logic [31:0] RESULT_BUS,
  output logic [31:0] RESULT_LO,
  output logic [31:0] RESULT_HI,
  output logic        MUL_BUSY,
  output logic        MUL_DONE,
  output logic        MUL_N,
  output logic        MUL_Z
);
  localparam int N_ITER = 32 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [63:0] acc, mcand, step, fin;
  logic [31:0] a_lat, c_lat, b_abs, c_abs;
  logic [5:0]  cnt;
  logic        neg, acc_en, long_en, sgn;
  assign sgn   = MUL_LONG & MUL_SIGNED;
  assign b_abs = (sgn && B_BUS[31]) ? -B_BUS : B_BUS;
  assign c_abs = (sgn && C_BUS[31]) ? -C_BUS : C_BUS;
  assign step  = acc + mcand * 64'(c_lat[BITS_PER_CYCLE-1:0]);
  assign fin   = long_en ? (neg ? -acc : acc) : {32'd0, acc[31:0] + (acc_en ? a_lat : 32'd0)};
  assign RESULT_BUS = MUL_GATE_LO ? RESULT_LO : MUL_GATE_HI ? RESULT_HI : 32'bz;
  // next-state and busy decode
  always_comb begin
    state_nx = state;
    MUL_BUSY = state != IDLE;
    case (state)
      IDLE:    state_nx = MUL_START ? CALC : IDLE;
      CALC:    state_nx = (cnt == 6'(N_ITER - 1)) ? FIX : CALC;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // operand latch, shift-add datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      mcand     <= '0;
      a_lat     <= '0;
      c_lat     <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      acc_en    <= 1'b0;
      long_en   <= 1'b0;
      RESULT_LO <= '0;
      RESULT_HI <= '0;
      MUL_DONE  <= 1'b0;
      MUL_N     <= 1'b0;
      MUL_Z     <= 1'b0;
    end else begin
      MUL_DONE <= state == FIX;
      if (state == IDLE && MUL_START) begin
        acc     <= '0;
        mcand   <= {32'd0, b_abs};
        a_lat   <= A_BUS;
        c_lat   <= c_abs;
        cnt     <= '0;
        neg     <= sgn & (B_BUS[31] ^ C_BUS[31]);
        acc_en  <= MUL_ACC;
        long_en <= MUL_LONG;
      end
      if (state == CALC) begin
        acc   <= step;
        mcand <= mcand << BITS_PER_CYCLE;
        c_lat <= c_lat >> BITS_PER_CYCLE;
        cnt   <= cnt + 6'd1;
      end
      if (state == FIX) begin
        RESULT_LO <= fin[31:0];
        RESULT_HI <= fin[63:32];
        MUL_N     <= long_en ? fin[63] : fin[31];
        MUL_Z     <= fin == 64'd0;
      end
    end
  end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed-vector self-checking bench for mul_unit
module tb_mul_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, acc = 1'b0, lng = 1'b0, sgn = 1'b0, gate_lo = 1'b0, gate_hi = 1'b0;
  logic [31:0] a_bus = '0, b_bus = '0, c_bus = '0;
  logic [31:0] bus0, lo0, hi0, bus1, lo1, hi1;
  logic        busy0, done0, n0, z0, busy1, done1, n1, z1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mul_unit #(.BITS_PER_CYCLE(8)) u_dut (
    .clk(clk), .rst(rst), .MUL_START(start), .MUL_ACC(acc), .MUL_LONG(lng), .MUL_SIGNED(sgn),
    .A_BUS(a_bus), .B_BUS(b_bus), .C_BUS(c_bus), .MUL_GATE_LO(gate_lo), .MUL_GATE_HI(gate_hi),
    .RESULT_BUS(bus0), .RESULT_LO(lo0), .RESULT_HI(hi0), .MUL_BUSY(busy0), .MUL_DONE(done0),
    .MUL_N(n0), .MUL_Z(z0));

  mul_unit #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .MUL_START(start), .MUL_ACC(acc), .MUL_LONG(lng), .MUL_SIGNED(sgn),
    .A_BUS(a_bus), .B_BUS(b_bus), .C_BUS(c_bus), .MUL_GATE_LO(gate_lo), .MUL_GATE_HI(gate_hi),
    .RESULT_BUS(bus1), .RESULT_LO(lo1), .RESULT_HI(hi1), .MUL_BUSY(busy1), .MUL_DONE(done1),
    .MUL_N(n1), .MUL_Z(z1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic m_acc, input logic m_lng, input logic m_sgn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    acc = m_acc; lng = m_lng; sgn = m_sgn; a_bus = a; b_bus = b; c_bus = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_bus = ~a; b_bus = ~b; c_bus = ~c;
  endtask

  task automatic wait_done();
    int n = 1;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'd0, done0}, 64'd1);
  endtask

  task automatic op(input logic m_acc, input logic m_lng, input logic m_sgn,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    launch(m_acc, m_lng, m_sgn, a, b, c);
    wait_done();
  endtask

  initial begin
    int d0 = 0, d1 = 0, bc0 = 0, bc1 = 0, dcount = 0;
    repeat (2) @(negedge clk);
    check("rst_lo", {32'd0, lo0}, 64'd0);
    check("rst_hi", {32'd0, hi0}, 64'd0);
    check("rst_flags", {60'd0, busy0, done0, n0, z0}, 64'd0);
    rst = 1'b0;

    launch(1'b0, 1'b0, 1'b0, 32'd0, 32'd9, 32'd2);
    for (int n = 1; n <= 60 && d1 == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy0) bc0++;
      if (busy1) bc1++;
      if (done0 && d0 == 0) d0 = n;
      if (done1) d1 = n;
    end
    check("lat8_done", 64'(d0), 64'd6);
    check("lat8_busy", 64'(bc0), 64'd5);
    check("lat1_done", 64'(d1), 64'd34);
    check("lat1_busy", 64'(bc1), 64'd33);
    check("mul_9x2", {hi0, lo0}, 64'd18);
    check("mul_9x2_bpc1", {hi1, lo1}, 64'd18);
    check("mul_9x2_nz", {62'd0, n0, z0}, 64'd0);
    gate_lo = 1'b1;
    #1 check("bus_lo", {32'd0, bus0}, 64'h12);
    gate_lo = 1'b0;

    op(1'b1, 1'b0, 1'b0, 32'd5, 32'd3, 32'd7);
    check("mla", {hi0, lo0}, 64'd26);
    op(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1234);
    check("mul_zero", {hi0, lo0}, 64'd0);
    check("mul_zero_z", {63'd0, z0}, 64'd1);
    op(1'b0, 1'b0, 1'b1, 32'd0, 32'hFFFFFFFE, 32'd3);
    check("mul_short_sgn_ignored", {hi0, lo0}, 64'h00000000_FFFFFFFA);
    check("mul_short_n", {62'd0, n0, z0}, 64'd2);
    op(1'b1, 1'b1, 1'b1, 32'd100, 32'hFFFFFFFE, 32'd3);
    check("smull", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFFA);
    check("smull_n", {62'd0, n0, z0}, 64'd2);
    op(1'b0, 1'b1, 1'b1, 32'd0, 32'h80000000, 32'h80000000);
    check("smull_min", {hi0, lo0}, 64'h40000000_00000000);
    op(1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("umull", {hi0, lo0}, 64'hFFFFFFFE_00000001);
    check("umull_n", {62'd0, n0, z0}, 64'd2);
    gate_hi = 1'b1;
    #1 check("bus_hi", {32'd0, bus0}, 64'hFFFFFFFE);
    gate_lo = 1'b1;
    #1 check("bus_prio", {32'd0, bus0}, 64'h1);
    gate_lo = 1'b0; gate_hi = 1'b0;

    launch(1'b0, 1'b0, 1'b0, 32'd0, 32'd4, 32'd5);
    @(negedge clk);
    b_bus = 32'd100; c_bus = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore", {63'd0, busy0}, 64'd1);
    check("hold_prev", {hi0, lo0}, 64'hFFFFFFFE_00000001);
    wait_done();
    check("first_kept", {hi0, lo0}, 64'd20);
    b_bus = 32'd6; c_bus = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {63'd0, busy0}, 64'd1);
    check("b2b_hold", {32'd0, lo0}, 64'd20);
    wait_done();
    check("b2b_result", {hi0, lo0}, 64'd42);
    @(negedge clk);
    check("no_queue", {62'd0, busy0, done0}, 64'd0);

    launch(1'b0, 1'b0, 1'b0, 32'd0, 32'd9, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy0}, 64'd0);
    check("abort_lo", {32'd0, lo0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    op(1'b0, 1'b0, 1'b0, 32'd0, 32'd3, 32'd3);
    check("after_abort", {hi0, lo0}, 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
